// File: rtl/ex_hazard_ctrl_if.sv
// Hazard controller port bundle: pipeline-side inputs and control outputs.
// Optional macro HAZARD_PERF_CNT_EN adds the performance counter outputs.
interface ex_hazard_ctrl_if #(
  parameter int NB_ADDR = 5
);
  logic [NB_ADDR-1:0] i_id_rs;
  logic [NB_ADDR-1:0] i_id_rt;
  logic [NB_ADDR-1:0] i_ex_rs;
  logic [NB_ADDR-1:0] i_ex_rt;
  logic               i_ex_mem_read;
  logic [NB_ADDR-1:0] i_ex_write_reg;
  logic [NB_ADDR-1:0] i_mem_write_reg;
  logic               i_mem_reg_write;
  logic [NB_ADDR-1:0] i_wb_write_reg;
  logic               i_wb_reg_write;
  logic               i_branch_taken;
  logic               i_halt;
  logic [1:0]         o_ctrl_muxA_corto;
  logic [1:0]         o_ctrl_muxB_corto;
  logic               o_pc_write;
  logic               o_ifid_write;
  logic               o_idex_bubble;
  logic               o_flush;
  logic               o_halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]        o_stall_cnt;
  logic [31:0]        o_flush_cnt;
  logic [31:0]        o_halt_cycles;
`endif

  // Pipeline side: drives stage information, consumes hazard controls.
  modport master (
    output i_id_rs, i_id_rt, i_ex_rs, i_ex_rt, i_ex_mem_read, i_ex_write_reg,
           i_mem_write_reg, i_mem_reg_write, i_wb_write_reg, i_wb_reg_write,
           i_branch_taken, i_halt,
    input  o_ctrl_muxA_corto, o_ctrl_muxB_corto, o_pc_write, o_ifid_write,
           o_idex_bubble, o_flush, o_halted
`ifdef HAZARD_PERF_CNT_EN
    , input o_stall_cnt, o_flush_cnt, o_halt_cycles
`endif
  );

  // Hazard controller side.
  modport slave (
    input  i_id_rs, i_id_rt, i_ex_rs, i_ex_rt, i_ex_mem_read, i_ex_write_reg,
           i_mem_write_reg, i_mem_reg_write, i_wb_write_reg, i_wb_reg_write,
           i_branch_taken, i_halt,
    output o_ctrl_muxA_corto, o_ctrl_muxB_corto, o_pc_write, o_ifid_write,
           o_idex_bubble, o_flush, o_halted
`ifdef HAZARD_PERF_CNT_EN
    , output o_stall_cnt, o_flush_cnt, o_halt_cycles
`endif
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding selects plus a small
// FSM sequencing load-use stalls, branch flushes and the halt drain.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush/halt counters.
//
// state | meaning
// RUN   | normal issue; reacts to branch, load-use and halt
// STALL | recovery cycle after a load-use bubble; decides exactly like RUN
// FLUSH | cycle after a taken branch; everything ignored, back to RUN
// DRAIN | halt accepted; front end frozen while EX/MEM/WB empty out
// HALT  | pipeline drained; left only by reset
module ex_hazard_ctrl #(
  parameter int NB_ADDR      = 5,
  parameter int NB_DRAIN     = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  ex_hazard_ctrl_if.slave hz
);

  typedef enum logic [2:0] {
    S_RUN,
    S_STALL,
    S_FLUSH,
    S_DRAIN,
    S_HALT
  } state_t;

  localparam logic [NB_ADDR-1:0]  REG_ZERO   = '0;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;

  logic       load_use;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_write, ifid_write, idex_bubble, flush, halted;

  // Forwarding selects: MEM result beats WB result, r0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.i_mem_reg_write && hz.i_mem_write_reg != REG_ZERO &&
        hz.i_mem_write_reg == hz.i_ex_rs)
      fwd_a = 2'b01;
    else if (hz.i_wb_reg_write && hz.i_wb_write_reg != REG_ZERO &&
             hz.i_wb_write_reg == hz.i_ex_rs)
      fwd_a = 2'b10;
    if (hz.i_mem_reg_write && hz.i_mem_write_reg != REG_ZERO &&
        hz.i_mem_write_reg == hz.i_ex_rt)
      fwd_b = 2'b01;
    else if (hz.i_wb_reg_write && hz.i_wb_write_reg != REG_ZERO &&
             hz.i_wb_write_reg == hz.i_ex_rt)
      fwd_b = 2'b10;
  end

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    load_use = hz.i_ex_mem_read && hz.i_ex_write_reg != REG_ZERO &&
               (hz.i_ex_write_reg == hz.i_id_rs ||
                hz.i_ex_write_reg == hz.i_id_rt);
  end

  // Next state, drain counter and control outputs from state plus inputs.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      // A halt seen during the recovery cycle must not be lost, so STALL
      // takes the same decisions as RUN.
      S_RUN, S_STALL: begin
        if (hz.i_branch_taken) begin
          flush   = 1'b1;
          state_d = S_FLUSH;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = S_STALL;
        end else if (hz.i_halt) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (hz.i_branch_taken) begin
          flush       = 1'b1;
          drain_cnt_d = '0;
          state_d     = S_FLUSH;
        end else if (drain_cnt_q == '0) begin
          state_d = S_HALT;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_d     = S_RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  // State and drain counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign hz.o_ctrl_muxA_corto = fwd_a;
  assign hz.o_ctrl_muxB_corto = fwd_b;
  assign hz.o_pc_write        = pc_write;
  assign hz.o_ifid_write      = ifid_write;
  assign hz.o_idex_bubble     = idex_bubble;
  assign hz.o_flush           = flush;
  assign hz.o_halted          = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, halt_cycles_q;
  logic        in_drain_or_halt;

  assign in_drain_or_halt = (state_q == S_DRAIN) || (state_q == S_HALT);

  // Saturating event counters; bubbles during the halt drain are not stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      halt_cycles_q <= '0;
    end else begin
      if (idex_bubble && !in_drain_or_halt && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (state_q == S_HALT && halt_cycles_q != 32'hFFFF_FFFF)
        halt_cycles_q <= halt_cycles_q + 32'd1;
    end
  end

  assign hz.o_stall_cnt   = stall_cnt_q;
  assign hz.o_flush_cnt   = flush_cnt_q;
  assign hz.o_halt_cycles = halt_cycles_q;
`endif

endmodule
